seg_scan_controller: RTL and testbench
======================================

// Module: seg_scan_controller
// PURPOSE
//  Time-multiplexed N-digit 7-segment display driver. Latches hex digits, decimal points and
//  per-digit blank flags, then scans one digit per slot with anti-ghost guard time and PWM
//  brightness. Sits between a register/counter datapath and the board's segment/anode pins.
//  Tear-free: a new load is shown only from the next frame boundary.
// PARAMETERS
//  NUM_DIGITS  4      digits scanned, 1..8
//  CLK_DIV     50000  clk cycles per digit slot, > GUARD+1
//  GUARD       16     cycles at start of each slot with all anodes off
//  BRIGHT_W    4      brightness control width
//  SEG_ACT_LOW 1      1: seg pins active-low
//  AN_ACT_LOW  1      1: anode pins active-low
// PORTS
//  clk         in   1             system clock
//  rst         in   1             synchronous active-high reset
//  d           in   4*NUM_DIGITS  hex digits; digit i = d[4i+3:4i], digit 0 rightmost
//  dp          in   NUM_DIGITS    decimal point per digit, 1 = lit
//  blank       in   NUM_DIGITS    1 = digit dark
//  load        in   1             capture d/dp/blank this edge
//  brightness  in   BRIGHT_W      0 = off, all-ones = full on
//  seg         out  8             {dp,g,f,e,d,c,b,a}, polarity per SEG_ACT_LOW
//  an          out  NUM_DIGITS    one-hot digit enable, polarity per AN_ACT_LOW
//  frame_done  out  1             1-cycle pulse when last digit slot ends
// BEHAVIOUR
//  - Reset: seg and an all inactive; frame_done=0; prescaler=0; digit index=0; pwm_cnt=0;
//    active and pending regs: d=0, dp=0, blank=all 1 (dark until first load); pending_flag=0.
//  - Counters: prescaler 0..CLK_DIV-1 wraps; index increments on wrap, NUM_DIGITS-1 -> 0.
//    pwm_cnt is free-running BRIGHT_W bits, +1 every cycle.
//  - Boundary = prescaler==CLK_DIV-1 && index==NUM_DIGITS-1. frame_done registered, high the cycle after.
//  - load, no boundary: inputs -> pending, pending_flag=1. Boundary, no load: if pending_flag
//    then pending -> active, flag cleared. load at boundary: inputs -> active directly,
//    flag cleared, pending discarded. Back-to-back loads: last one wins.
//  - Digit enable: on when prescaler>=GUARD && !active_blank[index] &&
//    (brightness==all-ones || pwm_cnt<brightness). brightness=0 -> an always inactive.
//  - Decode, active-high before polarity: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F
//    9:6F A:77 b:7C C:39 d:5E E:79 F:71; bit7 = active_dp[index].
//  - seg and an are registered: one-cycle latency from index/prescaler/active state.
//    A blanked digit drives seg all-inactive too.
//  - Exactly one an bit is active or none; never two in the same cycle.
//  - rst mid-frame: all state returns to reset values on the next edge; load is ignored while rst=1.
//  - NUM_DIGITS=1: index fixed at 0; boundary every slot.
// STRUCTURE
//  - Shared package seg_pkg: the 16-entry segment constants, SEG_OFF, and a function
//    seg_apply_pol(value, act_low).
//  - One sub-module: seg_hex_lut (4-bit in -> 7-bit a..g, combinational), one instance on the
//    muxed active digit.
//  - Top holds prescaler, index, pwm_cnt, pending/active regs and output regs.
// TESTING (NUM_DIGITS=4, CLK_DIV=8, GUARD=1, BRIGHT_W=4, both polarities active-low)
//  1. Reset 3 cycles -> seg=8'hFF, an=4'hF, frame_done=0 for 40 cycles (all blank).
//  2. load d=16'h12AF, dp=4'b0100, blank=0, brightness=F -> from the next frame, slot 0
//     seg=~8'h71 and an=4'b1110 for 7 of 8 cycles (1 guard cycle). Slot 2 seg=~8'hDB.
//     frame_done every 32 cycles.
//  3. load d=16'h0000 mid-frame -> the rest of the frame still shows 12AF; the next frame shows 0000.
//  4. brightness=4 -> over a digit on-window, an active iff pwm_cnt<4. brightness=0 -> an=4'hF always.
//  5. blank=4'b1010 -> digits 1 and 3: an and seg all inactive in their slots; digits 0 and 2 normal.
//  6. Assert rst during slot 2 -> next edge: an=4'hF, index=0, display blank; load in the same
//     cycle as rst is ignored.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan controller: hex glyphs, the blank
// pattern and a helper that maps active-high values onto the pin polarity.
package seg_pkg;

    // Glyphs as {g,f,e,d,c,b,a}, active-high, indexed by hex value.
    localparam logic [6:0] SEG_HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    localparam logic [7:0] SEG_OFF = 8'h00;

    function automatic logic [7:0] seg_apply_pol(input logic [7:0] value, input logic act_low);
        return act_low ? ~value : value;
    endfunction

endpackage

// File: rtl/seg_scan_controller_if.sv
// Pin-level bundle between the datapath/board and seg_scan_controller.
// There is no valid/ready handshake: load is a one-cycle capture strobe that is
// always accepted (except during rst); seg/an/frame_done are free-running outputs.
interface seg_scan_controller_if #(
    parameter int NUM_DIGITS = 4,
    parameter int BRIGHT_W   = 4
);
    logic [4*NUM_DIGITS-1:0] d;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   blank;
    logic                    load;
    logic [BRIGHT_W-1:0]     brightness;
    logic [7:0]              seg;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_done;

    modport master (
        output d, dp, blank, load, brightness,
        input  seg, an, frame_done
    );

    modport slave (
        input  d, dp, blank, load, brightness,
        output seg, an, frame_done
    );
endinterface

// File: rtl/seg_hex_lut.sv
// Combinational hex-to-segment decoder; output is {g,f,e,d,c,b,a}, active-high.
module seg_hex_lut
    import seg_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);
    assign o_seg = SEG_HEX[i_hex];
endmodule

// File: rtl/seg_scan_controller.sv
// Time-multiplexed N-digit 7-segment driver with guard time, PWM dimming and
// frame-aligned (tear-free) update of the displayed value.
module seg_scan_controller
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int CLK_DIV     = 50000,
    parameter int GUARD       = 16,
    parameter int BRIGHT_W    = 4,
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter bit AN_ACT_LOW  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    seg_scan_controller_if.slave bus
);
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] GUARD_END = PW'(GUARD);
    localparam logic [IW-1:0] INDEX_MAX = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF = AN_ACT_LOW ? '1 : '0;

    logic [PW-1:0]           r_presc;
    logic [IW-1:0]           r_index;
    logic [BRIGHT_W-1:0]     r_pwm;

    logic [4*NUM_DIGITS-1:0] r_act_d;
    logic [NUM_DIGITS-1:0]   r_act_dp;
    logic [NUM_DIGITS-1:0]   r_act_blank;
    logic [4*NUM_DIGITS-1:0] r_pend_d;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic [NUM_DIGITS-1:0]   r_pend_blank;
    logic                    r_pend_flag;

    logic [7:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_an;
    logic                    r_frame_done;

    logic                    w_slot_end;
    logic                    w_boundary;
    logic [3:0]              w_digit;
    logic [6:0]              w_glyph;
    logic                    w_blank;
    logic                    w_pwm_on;
    logic                    w_an_on;
    logic [NUM_DIGITS-1:0]   w_an_act;
    logic [7:0]              w_seg_act;

    assign w_slot_end = (r_presc == PRESC_MAX);
    assign w_boundary = w_slot_end && (r_index == INDEX_MAX);

    assign w_digit = r_act_d[4*int'(r_index) +: 4];
    assign w_blank = r_act_blank[r_index];

    seg_hex_lut u_lut (
        .i_hex (w_digit),
        .o_seg (w_glyph)
    );

    // All-ones brightness must be fully on, which pwm_cnt < brightness alone cannot give.
    assign w_pwm_on = (bus.brightness == '1) || (r_pwm < bus.brightness);
    assign w_an_on  = (r_presc >= GUARD_END) && !w_blank && w_pwm_on;

    always_comb begin
        w_an_act          = '0;
        w_an_act[r_index] = w_an_on;
    end

    // Segments follow the digit through guard/PWM-off time; only blanking darkens them.
    assign w_seg_act = w_blank ? SEG_OFF : {r_act_dp[r_index], w_glyph};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
            r_index <= '0;
            r_pwm   <= '0;
        end else begin
            r_pwm <= r_pwm + 1'b1;
            if (w_slot_end) begin
                r_presc <= '0;
                r_index <= (r_index == INDEX_MAX) ? '0 : r_index + 1'b1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

    // A load on the boundary edge goes straight to the active set and supersedes any pending one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_act_d      <= '0;
            r_act_dp     <= '0;
            r_act_blank  <= '1;
            r_pend_d     <= '0;
            r_pend_dp    <= '0;
            r_pend_blank <= '1;
            r_pend_flag  <= 1'b0;
        end else if (bus.load && w_boundary) begin
            r_act_d     <= bus.d;
            r_act_dp    <= bus.dp;
            r_act_blank <= bus.blank;
            r_pend_flag <= 1'b0;
        end else if (bus.load) begin
            r_pend_d     <= bus.d;
            r_pend_dp    <= bus.dp;
            r_pend_blank <= bus.blank;
            r_pend_flag  <= 1'b1;
        end else if (w_boundary && r_pend_flag) begin
            r_act_d     <= r_pend_d;
            r_act_dp    <= r_pend_dp;
            r_act_blank <= r_pend_blank;
            r_pend_flag <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg        <= seg_apply_pol(SEG_OFF, SEG_ACT_LOW);
            r_an         <= AN_OFF;
            r_frame_done <= 1'b0;
        end else begin
            r_seg        <= seg_apply_pol(w_seg_act, SEG_ACT_LOW);
            r_an         <= AN_ACT_LOW ? ~w_an_act : w_an_act;
            r_frame_done <= w_boundary;
        end
    end

    assign bus.seg        = r_seg;
    assign bus.an         = r_an;
    assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Randomized self-checking bench for seg_scan_controller (4 digits, 8-cycle slots,
// 1-cycle guard, both polarities active-low) against a cycle-count based model.
module tb_seg_scan_controller;
    localparam int N        = 4;
    localparam int CLK_DIV  = 8;
    localparam int GUARD    = 1;
    localparam int BW       = 4;
    localparam int FRAME    = N * CLK_DIV;

    logic clk;
    logic rst;

    seg_scan_controller_if #(.NUM_DIGITS(N), .BRIGHT_W(BW)) bus ();

    seg_scan_controller #(
        .NUM_DIGITS  (N),
        .CLK_DIV     (CLK_DIV),
        .GUARD       (GUARD),
        .BRIGHT_W    (BW),
        .SEG_ACT_LOW (1'b1),
        .AN_ACT_LOW  (1'b1)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // checker
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // reference model: everything derives from cycles elapsed since reset
    int unsigned     m_cyc;
    logic [4*N-1:0]  m_act_d,  m_pend_d;
    logic [N-1:0]    m_act_dp, m_pend_dp, m_act_bl, m_pend_bl;
    bit              m_flag;
    logic [13:0]     exp_q[$];

    function automatic logic [6:0] glyph(input logic [3:0] h);
        logic [6:0] tbl [16];
        tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return tbl[h];
    endfunction

    task automatic model_reset();
        m_cyc     = 0;
        m_act_d   = '0;
        m_act_dp  = '0;
        m_act_bl  = '1;
        m_pend_d  = '0;
        m_pend_dp = '0;
        m_pend_bl = '1;
        m_flag    = 0;
    endtask

    // One clock: predict the post-edge outputs, advance the model, then compare.
    task automatic cycle();
        logic [7:0]   es;
        logic [N-1:0] ea;
        logic         ef, seg_valid;
        logic [13:0]  e;
        int           slot_pos, digit, pwm;
        bit           lit, boundary;
        if (rst) begin
            es = 8'hFF; ea = '1; ef = 1'b0; seg_valid = 1'b1;
            model_reset();
        end else begin
            slot_pos = int'(m_cyc % CLK_DIV);
            digit    = int'((m_cyc / CLK_DIV) % N);
            pwm      = int'(m_cyc % (1 << BW));
            boundary = (m_cyc % FRAME) == FRAME - 1;
            lit = (slot_pos >= GUARD) && !m_act_bl[digit] &&
                  ((bus.brightness == 4'hF) || (pwm < int'(bus.brightness)));
            ea = '1;
            if (lit) ea[digit] = 1'b0;
            es = m_act_bl[digit] ? 8'hFF : ~{m_act_dp[digit], glyph(m_act_d[4*digit +: 4])};
            seg_valid = m_act_bl[digit] || lit;
            ef = boundary;
            if (bus.load && boundary) begin
                m_act_d = bus.d; m_act_dp = bus.dp; m_act_bl = bus.blank; m_flag = 0;
            end else if (bus.load) begin
                m_pend_d = bus.d; m_pend_dp = bus.dp; m_pend_bl = bus.blank; m_flag = 1;
            end else if (boundary && m_flag) begin
                m_act_d = m_pend_d; m_act_dp = m_pend_dp; m_act_bl = m_pend_bl; m_flag = 0;
            end
            m_cyc++;
        end
        exp_q.push_back({seg_valid, ef, ea, es});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("an", 32'(bus.an), 32'(e[11:8]));
        check("frame_done", 32'(bus.frame_done), 32'(e[12]));
        if (e[13]) check("seg", 32'(bus.seg), 32'(e[7:0]));
    endtask

    // drivers
    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic load_once(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
        bus.d = d; bus.dp = dp; bus.blank = bl; bus.load = 1'b1;
        cycle();
        bus.load = 1'b0;
    endtask

    task automatic run_to_frame_pos(input int pos);
        for (int i = 0; i < FRAME && int'(m_cyc % FRAME) != pos; i++) cycle();
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        bus.d = 16'hBEEF; bus.dp = 4'hF; bus.blank = 4'h0;
        bus.load = 1'b1; bus.brightness = 4'hF;

        // reset with load asserted; display must stay dark afterwards
        run(3);
        rst = 1'b0; bus.load = 1'b0;
        run(40);

        // 12AF, dp on digit 2, full brightness
        load_once(16'h12AF, 4'b0100, 4'b0000);
        run(80);

        // mid-frame load shows only from the next frame
        run_to_frame_pos(10);
        load_once(16'h0000, 4'b0000, 4'b0000);
        run(64);

        // PWM dimming and off
        load_once(16'h3C5E, 4'b1001, 4'b0000);
        bus.brightness = 4'd4;
        run(80);
        bus.brightness = 4'd0;
        run(40);
        bus.brightness = 4'hF;

        // per-digit blanking
        load_once(16'h9876, 4'b0011, 4'b1010);
        run(64);

        // load exactly on the boundary cycle, then back-to-back loads
        run_to_frame_pos(FRAME - 1);
        load_once(16'h4D21, 4'b0110, 4'b0001);
        run(10);
        load_once(16'h1111, 4'b0000, 4'b0000);
        load_once(16'hE7B0, 4'b1000, 4'b0100);
        run(70);

        // pending load followed by a boundary load that discards it
        run_to_frame_pos(5);
        load_once(16'hAAAA, 4'b1111, 4'b0000);
        run_to_frame_pos(FRAME - 1);
        load_once(16'h5F08, 4'b0010, 4'b0000);
        run(40);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            bus.load = ($urandom_range(0, 5) == 0);
            bus.d     = 16'($urandom);
            bus.dp    = 4'($urandom);
            bus.blank = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 99) == 0) bus.brightness = 4'($urandom);
            cycle();
        end
        bus.load = 1'b0;
        bus.brightness = 4'hF;
        load_once(16'h2468, 4'b0000, 4'b0000);
        run(40);

        // reset during slot 2 with a simultaneous load
        run_to_frame_pos(2 * CLK_DIV + 3);
        rst = 1'b1;
        bus.d = 16'h7777; bus.dp = 4'hF; bus.blank = 4'h0; bus.load = 1'b1;
        cycle();
        rst = 1'b0; bus.load = 1'b0;
        run(40);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
